// File: rtl/note_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | note_sequencer_pkg                                                   |
// | Shared mode encodings and size defaults for the note sequencer.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package note_sequencer_pkg;

   localparam int NOTE_W_DFLT = 32;
   localparam int ADDR_W_DFLT = 6;
   localparam int NOTE_DEPTH  = 64;

   // Mode encodings double as the sequencer state register values.
   localparam logic [1:0] MODE_IDLE  = 2'd0;
   localparam logic [1:0] MODE_REC   = 2'd1;
   localparam logic [1:0] MODE_PLAY  = 2'd2;
   localparam logic [1:0] MODE_FETCH = 2'd3;

endpackage
`default_nettype wire

// File: rtl/note_sequencer_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | note_accumulator                                                     |
// | OR-accumulates the live note word over one beat; clears on tick.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module note_accumulator
   import note_sequencer_pkg::*;
#(
   parameter int NOTE_W = NOTE_W_DFLT
)
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              clr,
   input  logic              en,
   input  logic              beat,
   input  logic [NOTE_W-1:0] note_in,
   output logic [NOTE_W-1:0] merged
);

   logic [NOTE_W-1:0] r_acc;

   // merged includes the current cycle so the tick-cycle note is not lost.
   assign merged = r_acc | note_in;

   always_ff @(posedge clk) begin
      if (!resetn || clr || beat) begin
         r_acc <= '0;
      end else if (en) begin
         r_acc <= merged;
      end
   end

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | note_sequencer                                                       |
// | Beat-driven record/playback controller for the note RAM.             |
// | Option: NOTE_SEQ_LOOP_EN makes playback wrap until stop.             |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module note_sequencer
   import note_sequencer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DFLT,
   parameter int NOTE_W = NOTE_W_DFLT
)
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              tick,
   input  logic              start_rec,
   input  logic              start_play,
   input  logic              stop,
   input  logic [NOTE_W-1:0] note_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [NOTE_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [NOTE_W-1:0] mem_rdata,
   output logic [NOTE_W-1:0] note_out,
   output logic              note_valid,
   output logic [ADDR_W:0]   rec_len,
   output logic [1:0]        mode
);

`ifdef NOTE_SEQ_LOOP_EN
   localparam bit c_loop_en = 1'b1;
`else
   localparam bit c_loop_en = 1'b0;
`endif

   localparam logic [ADDR_W:0]   c_full      = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W-1:0] c_last_addr = '1;

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_rec_len;
   logic              r_last;
   logic [NOTE_W-1:0] r_note_out;
   logic              r_note_valid;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [NOTE_W-1:0] r_mem_wdata;

   logic              w_in_rec;
   logic              w_acc_clr;
   logic              w_acc_en;
   logic              w_acc_beat;
   logic [NOTE_W-1:0] w_merged;
   logic [ADDR_W:0]   w_rd_inc;
   logic              w_rd_is_last;

   assign w_in_rec   = (r_state == MODE_REC);
   assign w_acc_clr  = ((r_state == MODE_IDLE) && start_rec) || (w_in_rec && stop);
   assign w_acc_en   = w_in_rec && !stop;
   assign w_acc_beat = w_in_rec && !stop && tick;

   assign w_rd_inc     = {1'b0, r_rd_ptr} + (ADDR_W+1)'(1);
   assign w_rd_is_last = (w_rd_inc == r_rec_len);

   note_accumulator #(
      .NOTE_W (NOTE_W)
   ) u_acc (
      .clk     (clk),
      .resetn  (resetn),
      .clr     (w_acc_clr),
      .en      (w_acc_en),
      .beat    (w_acc_beat),
      .note_in (note_in),
      .merged  (w_merged)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state      <= MODE_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_rec_len    <= '0;
         r_last       <= 1'b0;
         r_note_out   <= '0;
         r_note_valid <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
      end else begin
         r_mem_we     <= 1'b0;
         r_note_valid <= 1'b0;
         case (r_state)
            MODE_IDLE: begin
               if (start_rec) begin
                  r_wr_ptr  <= '0;
                  r_rec_len <= '0;
                  r_state   <= MODE_REC;
               end else if (start_play && (r_rec_len != '0)) begin
                  r_rd_ptr <= '0;
                  r_last   <= 1'b0;
                  r_state  <= MODE_PLAY;
               end
            end
            MODE_REC: begin
               if (stop) begin
                  r_state <= MODE_IDLE;
               end else if (tick) begin
                  r_mem_addr  <= r_wr_ptr;
                  r_mem_wdata <= w_merged;
                  r_mem_we    <= 1'b1;
                  r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
                  if (r_rec_len != c_full) begin
                     r_rec_len <= r_rec_len + (ADDR_W+1)'(1);
                  end
                  if (r_wr_ptr == c_last_addr) begin
                     r_state <= MODE_IDLE;
                  end
               end
            end
            MODE_PLAY: begin
               if (stop) begin
                  r_note_out <= '0;
                  r_state    <= MODE_IDLE;
               end else if (tick) begin
                  // The beat after the final word blanks the output.
                  if (r_last) begin
                     r_note_out <= '0;
                     r_last     <= 1'b0;
                     r_state    <= MODE_IDLE;
                  end else begin
                     r_mem_addr <= r_rd_ptr;
                     r_state    <= MODE_FETCH;
                  end
               end
            end
            MODE_FETCH: begin
               if (stop) begin
                  r_note_out <= '0;
                  r_state    <= MODE_IDLE;
               end else begin
                  r_note_out   <= mem_rdata;
                  r_note_valid <= 1'b1;
                  if (w_rd_is_last && c_loop_en) begin
                     r_rd_ptr <= '0;
                  end else begin
                     r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                     if (w_rd_is_last) begin
                        r_last <= 1'b1;
                     end
                  end
                  r_state <= MODE_PLAY;
               end
            end
            default: begin
               r_state <= MODE_IDLE;
            end
         endcase
      end
   end

   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign mem_we     = r_mem_we;
   assign note_out   = r_note_out;
   assign note_valid = r_note_valid;
   assign rec_len    = r_rec_len;
   assign mode       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_note_sequencer                                                    |
// | Self-checking bench: beat table, write/playback scoreboards.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_note_sequencer;
   import note_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        tick = 1'b0;
   logic        start_rec = 1'b0;
   logic        start_play = 1'b0;
   logic        stop = 1'b0;
   logic [31:0] note_in = '0;
   logic [5:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic [31:0] note_out;
   logic        note_valid;
   logic [6:0]  rec_len;
   logic [1:0]  mode;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] pre;
      logic [31:0] mid;
      logic [31:0] tk;
      logic [31:0] exp;
   } beat_t;

   typedef struct {
      logic [5:0]  addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } nt_t;

   beat_t tbl [5];
   wr_t   wq [$];
   nt_t   nq [$];
   logic [31:0] ram [NOTE_DEPTH];

   note_sequencer dut (
      .clk        (clk),
      .resetn     (resetn),
      .tick       (tick),
      .start_rec  (start_rec),
      .start_play (start_play),
      .stop       (stop),
      .note_in    (note_in),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .note_out   (note_out),
      .note_valid (note_valid),
      .rec_len    (rec_len),
      .mode       (mode)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Single-port RAM: synchronous write, read of the registered address.
   always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
   assign mem_rdata = ram[mem_addr];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] pat(input int i);
      return (32'h1 << (i % 32)) | (32'(i) << 8);
   endfunction

   task automatic rec_beat(input beat_t b, input int addr);
      note_in = b.pre;
      step(2);
      note_in = b.mid;
      step(1);
      note_in = b.pre;
      step(1);
      note_in = b.tk;
      tick = 1'b1;
      wq.push_back('{6'(addr), b.exp, cyc + 1});
      step(1);
      tick = 1'b0;
      note_in = '0;
   endtask

   always @(negedge clk) begin
      wr_t w;
      nt_t n;
      if (resetn) begin
         if (mem_we) begin
            if (wq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL wr_unexpected: got write addr=%0d data=%0h expected none", mem_addr, mem_wdata);
            end else begin
               w = wq.pop_front();
               chk("wr_addr", 64'(mem_addr), 64'(w.addr));
               chk("wr_data", 64'(mem_wdata), 64'(w.data));
               chk("wr_cycle", 64'(cyc), 64'(w.cyc));
            end
         end
         if (note_valid) begin
            if (nq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL note_unexpected: got note %0h expected none", note_out);
            end else begin
               n = nq.pop_front();
               chk("note_data", 64'(note_out), 64'(n.data));
               chk("note_cycle", 64'(cyc), 64'(n.cyc));
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{32'h1,        32'h1,  32'h1,        32'h1};
      tbl[1] = '{32'h40,       32'h40, 32'h40,       32'h40};
      tbl[2] = '{32'h41,       32'h41, 32'h41,       32'h41};
      tbl[3] = '{32'h0,        32'h2,  32'h8,        32'h0000000A};
      tbl[4] = '{32'h100,      32'h0,  32'h80000000, 32'h80000100};

      // Reset state
      step(2);
      chk("rst_mode", 64'(mode), 64'(MODE_IDLE));
      chk("rst_rec_len", 64'(rec_len), 64'd0);
      chk("rst_note_out", 64'(note_out), 64'd0);
      chk("rst_note_valid", 64'(note_valid), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      resetn = 1'b1;
      step(1);

      // start_play with nothing recorded
      start_play = 1'b1;
      step(1);
      start_play = 1'b0;
      chk("play_empty_mode", 64'(mode), 64'(MODE_IDLE));

      // start_rec wins over start_play
      start_rec = 1'b1;
      start_play = 1'b1;
      step(1);
      start_rec = 1'b0;
      start_play = 1'b0;
      chk("rec_wins_mode", 64'(mode), 64'(MODE_REC));
      for (int i = 0; i < 3; i++) rec_beat(tbl[i], i);

      // stop with tick in REC: partial beat discarded, no write
      note_in = 32'hFF;
      step(2);
      stop = 1'b1;
      tick = 1'b1;
      step(1);
      stop = 1'b0;
      tick = 1'b0;
      note_in = '0;
      chk("rec_stop_mode", 64'(mode), 64'(MODE_IDLE));
      chk("rec_stop_len", 64'(rec_len), 64'd3);
      step(2);
      chk("rec3_wq_empty", 64'(wq.size()), 64'd0);

      // Playback of three words; second beat holds tick into FETCH
      start_play = 1'b1;
      step(1);
      start_play = 1'b0;
      chk("play_mode", 64'(mode), 64'(MODE_PLAY));
      step(1);
      for (int i = 0; i < 3; i++) begin
         tick = 1'b1;
         nq.push_back('{tbl[i].exp, cyc + 2});
         step(1);
         tick = (i == 1);
         chk("fetch_mode", 64'(mode), 64'(MODE_FETCH));
         step(1);
         tick = 1'b0;
         step(2);
         chk("note_hold", 64'(note_out), 64'(tbl[i].exp));
         chk("play_mode_hold", 64'(mode), 64'(MODE_PLAY));
      end
      tick = 1'b1;
`ifdef NOTE_SEQ_LOOP_EN
      nq.push_back('{tbl[0].exp, cyc + 2});
      step(1);
      tick = 1'b0;
      step(3);
      chk("loop_note", 64'(note_out), 64'(tbl[0].exp));
      stop = 1'b1;
      step(1);
      stop = 1'b0;
`else
      step(1);
      tick = 1'b0;
`endif
      chk("play_end_mode", 64'(mode), 64'(MODE_IDLE));
      chk("play_end_note", 64'(note_out), 64'd0);
      step(2);

      // Second session: partial-beat pulses and MSB
      start_rec = 1'b1;
      step(1);
      start_rec = 1'b0;
      for (int i = 3; i < 5; i++) rec_beat(tbl[i], i - 3);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      chk("rec2_len", 64'(rec_len), 64'd2);

      // Stop during FETCH drops the read
      start_play = 1'b1;
      step(1);
      start_play = 1'b0;
      tick = 1'b1;
      nq.push_back('{tbl[3].exp, cyc + 2});
      step(1);
      tick = 1'b0;
      step(3);
      tick = 1'b1;
      step(1);
      tick = 1'b0;
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      chk("fetch_stop_mode", 64'(mode), 64'(MODE_IDLE));
      chk("fetch_stop_note", 64'(note_out), 64'd0);
      step(2);
      chk("fetch_stop_nq", 64'(nq.size()), 64'd0);

      // 70 ticks: only 64 writes, then IDLE
      start_rec = 1'b1;
      step(1);
      start_rec = 1'b0;
      for (int i = 0; i < 70; i++) begin
         note_in = pat(i);
         step(1);
         tick = 1'b1;
         if (i < 64) wq.push_back('{6'(i), pat(i), cyc + 1});
         step(1);
         tick = 1'b0;
         if (i == 62) chk("full_mode_62", 64'(mode), 64'(MODE_REC));
         if (i == 63) begin
            chk("full_mode_63", 64'(mode), 64'(MODE_IDLE));
            chk("full_len", 64'(rec_len), 64'd64);
         end
      end
      note_in = '0;
      step(2);
      chk("full_wq_empty", 64'(wq.size()), 64'd0);
      chk("full_len_after", 64'(rec_len), 64'd64);

      // Reset pulse in the middle of playback
      start_play = 1'b1;
      step(1);
      start_play = 1'b0;
      tick = 1'b1;
      nq.push_back('{pat(0), cyc + 2});
      step(1);
      tick = 1'b0;
      step(3);
      chk("pre_rst_note", 64'(note_out), 64'(pat(0)));
      resetn = 1'b0;
      step(1);
      resetn = 1'b1;
      chk("mid_rst_mode", 64'(mode), 64'(MODE_IDLE));
      chk("mid_rst_note", 64'(note_out), 64'd0);
      chk("mid_rst_len", 64'(rec_len), 64'd0);
      chk("mid_rst_we", 64'(mem_we), 64'd0);
      start_play = 1'b1;
      step(1);
      start_play = 1'b0;
      chk("post_rst_play", 64'(mode), 64'(MODE_IDLE));
      step(2);
      chk("end_wq_empty", 64'(wq.size()), 64'd0);
      chk("end_nq_empty", 64'(nq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
